eth_rx_frame_filter: RTL



---
 rtl/eth_rx_pkg.sv | 11 +
 rtl/eth_rx_sdp_ram.sv | 27 ++
 rtl/eth_rx_frame_filter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared types and defaults for the Rx store-and-forward frame filter.
package eth_rx_pkg;
    localparam int ETH_RX_DEPTH_DEF = 512;
    localparam int ETH_RX_CNT_W_DEF = 16;
    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } rx_word_t;
    typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DISCARD} wr_state_e;
endpackage

// File: rtl/eth_rx_sdp_ram.sv
// eth_rx_sdp_ram: simple dual-port RAM, one write port and one registered read port.
module eth_rx_sdp_ram #(
    parameter int W     = 73,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end
    // The read register holds its word until the next read is issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_q <= '0;
        else if (re_i) rdata_q <= mem[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/eth_rx_frame_filter.sv
// eth_rx_frame_filter: store-and-forward Rx buffer that forwards only complete, error-free frames.
// Statistics counters are built only when ETH_RX_FILTER_CNT_EN is defined; otherwise o_cnt_* read 0.
module eth_rx_frame_filter
    import eth_rx_pkg::*;
#(
    parameter int DEPTH = ETH_RX_DEPTH_DEF,
    parameter int CNT_W = ETH_RX_CNT_W_DEF
) (
    input  logic             i_pclk,
    input  logic             i_prst,
    input  logic             i_s_axis_tvalid,
    input  logic             i_s_axis_tlast,
    input  logic [7:0]       i_s_axis_tkeep,
    input  logic [63:0]      i_s_axis_tdata,
    input  logic             i_s_axis_tuser,
    output logic             o_s_axis_tready,
    output logic             o_m_axis_tvalid,
    output logic             o_m_axis_tlast,
    output logic [7:0]       o_m_axis_tkeep,
    output logic [63:0]      o_m_axis_tdata,
    output logic             o_m_axis_tuser,
    input  logic             i_m_axis_tready,
    output logic [CNT_W-1:0] o_cnt_good,
    output logic [CNT_W-1:0] o_cnt_err,
    output logic [CNT_W-1:0] o_cnt_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    wr_state_e st_q, st_d;
    logic rdy_q, beat, full, wr_en, commit, drop_err, rewind;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
    logic ram_vld_q, ram_vld_d, skd_vld_q, skd_vld_d, pop, ren, move;
    rx_word_t in_w, ram_w, skd_q, out_w;

    assign beat = i_s_axis_tvalid && rdy_q;
    assign full = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign in_w = {i_s_axis_tlast, i_s_axis_tkeep, i_s_axis_tdata};

    always_ff @(posedge i_pclk or posedge i_prst) begin
        if (i_prst) st_q <= WR_IDLE;
        else st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        if (beat) st_d = i_s_axis_tlast ? WR_IDLE : (st_q == WR_DISCARD || full) ? WR_DISCARD : WR_FRAME;
    end

    // A bad or overflowing frame rewinds the write pointer to the last committed frame boundary.
    always_comb begin
        wr_en       = beat && st_q != WR_DISCARD && !full;
        commit      = wr_en && i_s_axis_tlast && !i_s_axis_tuser;
        drop_err    = wr_en && i_s_axis_tlast && i_s_axis_tuser;
        rewind      = drop_err || (beat && st_q != WR_DISCARD && full);
        wr_ptr_d    = rewind ? wr_commit_q : wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        wr_commit_d = commit ? wr_ptr_q + PW'(1) : wr_commit_q;
    end

    // Output stage: RAM read register plus a skid register that is always the older entry.
    assign pop       = o_m_axis_tvalid && i_m_axis_tready;
    assign ren       = (rd_ptr_q != wr_commit_q) && !(ram_vld_q && skd_vld_q && !pop);
    assign move      = ram_vld_q && ren && !(!skd_vld_q && pop);
    assign ram_vld_d = ren || (ram_vld_q && !(!skd_vld_q && pop));
    assign skd_vld_d = move || (skd_vld_q && !pop);
    assign rd_ptr_d  = rd_ptr_q + PW'(ren);
    assign out_w     = skd_vld_q ? skd_q : ram_w;

    always_ff @(posedge i_pclk or posedge i_prst) begin
        if (i_prst) begin
            rdy_q       <= 1'b0;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            ram_vld_q   <= 1'b0;
            skd_vld_q   <= 1'b0;
            skd_q       <= '0;
        end else begin
            rdy_q       <= 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_vld_q   <= ram_vld_d;
            skd_vld_q   <= skd_vld_d;
            if (move) skd_q <= ram_w;
        end
    end

    eth_rx_sdp_ram #(.W($bits(rx_word_t)), .DEPTH(DEPTH)) u_ram (
        .clk_i   (i_pclk),
        .rst_i   (i_prst),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (in_w),
        .re_i    (ren),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_w)
    );

    assign o_s_axis_tready = rdy_q;
    assign o_m_axis_tvalid = ram_vld_q || skd_vld_q;
    assign o_m_axis_tlast  = out_w.last;
    assign o_m_axis_tkeep  = out_w.keep;
    assign o_m_axis_tdata  = out_w.data;
    assign o_m_axis_tuser  = 1'b0;

`ifdef ETH_RX_FILTER_CNT_EN
    logic drop_ovf;
    logic [CNT_W-1:0] cnt_good_q, cnt_err_q, cnt_ovf_q;
    assign drop_ovf = beat && i_s_axis_tlast && (st_q == WR_DISCARD || full);
    // Counters saturate at all-ones.
    always_ff @(posedge i_pclk or posedge i_prst) begin
        if (i_prst) begin
            cnt_good_q <= '0;
            cnt_err_q  <= '0;
            cnt_ovf_q  <= '0;
        end else begin
            cnt_good_q <= cnt_good_q + CNT_W'(commit && !(&cnt_good_q));
            cnt_err_q  <= cnt_err_q + CNT_W'(drop_err && !(&cnt_err_q));
            cnt_ovf_q  <= cnt_ovf_q + CNT_W'(drop_ovf && !(&cnt_ovf_q));
        end
    end
    assign o_cnt_good = cnt_good_q;
    assign o_cnt_err  = cnt_err_q;
    assign o_cnt_ovf  = cnt_ovf_q;
`else
    assign o_cnt_good = '0;
    assign o_cnt_err  = '0;
    assign o_cnt_ovf  = '0;
`endif
endmodule
